switch_pio_edge_in: RTL and testbench
=====================================

Name: switch_pio_edge_in

Overview:
- Parametrised Avalon-MM input PIO for board switches and push-buttons. Successor to the plain switch reader.
- Each input bit passes through a synchronizer and an optional debounce filter.
- Per-bit edge capture with write-1-to-clear, a per-bit interrupt mask and a level IRQ to the Nios II system.
- Sits on the Qsys slave fabric beside the other PIO blocks, with 32-bit registered read data.

Parameters:
- WIDTH, 10, number of input bits (1..32).
- SYNC_STAGES, 2, synchronizer flop depth (2..4).
- EDGE_TYPE, 0, edge captured per bit: 0 rising, 1 falling, 2 any.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a change (>=2). Used only with DEBOUNCE_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  raw asynchronous switch inputs.
- irq  out  1  level interrupt, active high.

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low. All flops clear on reset_n=0 regardless of clk.
- Register map, 32-bit, upper bits above WIDTH read 0:
  - 0: DATA (RO), the filtered stable value.
  - 1: STATUS (RO). bit0 = armed; bits 15:8 = WIDTH.
  - 2: IRQ_MASK (RW). Writes take writedata[WIDTH-1:0].
  - 3: EDGE_CAPTURE (W1C).
- Write accepted when chipselect=1 and write_n=0, effective on that clk edge. Writes to addresses 0 and 1 are ignored.
- readdata is updated every cycle from the mux of the current address: 1-cycle latency, no read strobe. Reset value 0.
- Synchronizer: SYNC_STAGES flops per bit, reset to 0. The synced value lags in_port by SYNC_STAGES cycles.
- Arm logic:
  - Counter runs from 0 after reset release.
  - armed is set once SYNC_STAGES+1 cycles have elapsed, then stays 1 until reset.
  - While armed=0: stable loads directly from synced, bypassing debounce, and edge capture is inhibited. A switch held high through reset therefore produces no capture.
- Edge detect: prev is stable delayed one cycle. Per bit:
  - rise = stable & ~prev
  - fall = ~stable & prev
  - ev selected by EDGE_TYPE.
- EDGE_CAPTURE[i] is set when armed and ev[i]=1. It is cleared by writing 1 to bit i at address 3; writing 0 has no effect. If set and clear coincide on the same bit, set wins and the bit stays 1.
- irq = |(EDGE_CAPTURE & IRQ_MASK). Combinational from registers only, so glitch-free. Reset value 0.
- Mask changes act immediately. Masking does not clear captured edges.
- Reset mid-operation clears DATA, IRQ_MASK, EDGE_CAPTURE, the counters, armed and irq. The arm sequence then restarts.
- Reset values: readdata=0, irq=0, IRQ_MASK=0, EDGE_CAPTURE=0.

Optional Feature:
- Macro: SWITCH_PIO_DEBOUNCE_EN.
- Defined: each bit has a counter of clog2(DEBOUNCE_CYCLES)+1 bits.
  - While synced[i] != stable[i], the counter increments.
  - When it reaches DEBOUNCE_CYCLES-1, stable[i] takes synced[i] on the next clock and the counter clears.
  - Any cycle with synced[i] == stable[i] clears the counter.
  - Total acceptance latency from in_port change is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - STATUS bit1 reads 1.
- Undefined: stable = synced registered once, latency SYNC_STAGES+1. No debounce counters are generated. STATUS bit1 reads 0.

Test Plan:
- Reset, then in_port=10'h3FF held through reset release, address=0 -> DATA reads 10'h3FF once armed; EDGE_CAPTURE=0; irq stays 0.
- EDGE_TYPE=0, IRQ_MASK=10'h001, in_port bit0 0->1 -> EDGE_CAPTURE=10'h001 at the expected latency and irq=1. Write 32'h1 to address 3 -> irq=0 the next cycle.
- Clear-vs-set collision: W1C write to bit 3 in the same cycle its rising edge is detected -> EDGE_CAPTURE[3]=1 and irq stays asserted if bit 3 is masked in.
- SWITCH_PIO_DEBOUNCE_EN defined, DEBOUNCE_CYCLES=16:
  - bit2 toggles with a 10-cycle high pulse -> DATA[2] unchanged, no capture.
  - bit2 held high for 20 cycles -> DATA[2]=1 after SYNC_STAGES+16 cycles.
- EDGE_TYPE=2, IRQ_MASK=0, bit5 1->0->1 -> EDGE_CAPTURE[5]=1 and irq=0. Then write IRQ_MASK=32'h20 -> irq=1 immediately.
- Assert reset_n=0 mid-run with captures pending and IRQ_MASK=10'h3FF -> irq, readdata, IRQ_MASK and EDGE_CAPTURE are 0 asynchronously; STATUS armed=0 until SYNC_STAGES+1 cycles after release.

Source files
------------

// File: rtl/switch_pio_edge_in_if.sv
// Avalon-MM slave bus bundle for switch_pio_edge_in: register select, write strobe and 32-bit data.
`timescale 1ns/1ps
interface switch_pio_edge_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/switch_pio_edge_in.sv
// Switch/button input PIO: synchronizer, optional debounce (SWITCH_PIO_DEBOUNCE_EN),
// per-bit edge capture with W1C, interrupt mask and level IRQ, registered 32-bit read data.
`timescale 1ns/1ps
module switch_pio_edge_in #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  switch_pio_edge_in_if.slave  bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  localparam int unsigned AW = $clog2(SYNC_STAGES + 1) + 1;
`ifdef SWITCH_PIO_DEBOUNCE_EN
  localparam logic DB_EN = 1'b1;
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
`else
  localparam logic DB_EN = 1'b0;
`endif

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] synced;
  logic [AW-1:0]    arm_cnt_q, arm_cnt_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] rise, fall, ev;
  logic             wr_en;
  logic             unused_wdata;

  assign synced       = sync_q[SYNC_STAGES-1];
  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    sync_d[0] = in_port;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    arm_cnt_d = armed_q ? arm_cnt_q : arm_cnt_q + 1'b1;
    armed_d   = armed_q | (arm_cnt_q == AW'(SYNC_STAGES));
  end

`ifdef SWITCH_PIO_DEBOUNCE_EN
  logic [DBW-1:0] db_cnt_q [WIDTH];
  logic [DBW-1:0] db_cnt_d [WIDTH];

  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      db_cnt_d[i] = '0;
      if (!armed_q) begin
        stable_d[i] = synced[i];
      end else if (synced[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = synced[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end
`else
  always_comb begin
    stable_d = synced;
  end
`endif

  // prev follows stable_d until armed so a level held through reset is not seen as an edge
  always_comb begin
    prev_d = armed_q ? stable_q : stable_d;
    rise   = stable_q & ~prev_q;
    fall   = ~stable_q & prev_q;
    case (EDGE_TYPE)
      0:       ev = rise;
      1:       ev = fall;
      default: ev = rise | fall;
    endcase
  end

  // a W1C hitting a bit on its edge cycle leaves it set: the OR of ev comes last
  always_comb begin
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr_en && bus.address == 2'd2) mask_d = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == 2'd3) cap_d = cap_q & ~bus.writedata[WIDTH-1:0];
    if (armed_q) cap_d = cap_d | ev;
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      2'd0: readdata_d[WIDTH-1:0] = stable_q;
      2'd1: begin
        readdata_d[0]    = armed_q;
        readdata_d[1]    = DB_EN;
        readdata_d[15:8] = 8'(WIDTH);
      end
      2'd2: readdata_d[WIDTH-1:0] = mask_q;
      default: readdata_d[WIDTH-1:0] = cap_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      arm_cnt_q  <= '0;
      armed_q    <= 1'b0;
      stable_q   <= '0;
      prev_q     <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      arm_cnt_q  <= arm_cnt_d;
      armed_q    <= armed_d;
      stable_q   <= stable_d;
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(cap_q & mask_q);

endmodule

// File: tb/tb_switch_pio_edge_in.sv
// Self-checking bench for switch_pio_edge_in: one rising-edge instance (A) and one any-edge instance (B).
`timescale 1ns/1ps
module tb_switch_pio_edge_in;

  localparam int unsigned W  = 10;
  localparam int unsigned S  = 2;
  localparam int unsigned DC = 16;
`ifdef SWITCH_PIO_DEBOUNCE_EN
  localparam int unsigned CAP_K = S + DC + 1;
  localparam logic [31:0] DBB   = 32'h2;
`else
  localparam int unsigned CAP_K = S + 2;
  localparam logic [31:0] DBB   = 32'h0;
`endif
  localparam int unsigned SETTLE = CAP_K + 3;
  localparam logic [31:0] STAT0  = 32'h0000_0A00 | DBB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a_n, rst_b_n;
  logic [W-1:0] in_a, in_b;
  logic         irq_a, irq_b;
  logic [31:0]  rd;

  switch_pio_edge_in_if bus_a ();
  switch_pio_edge_in_if bus_b ();

  switch_pio_edge_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DC)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .bus(bus_a), .in_port(in_a), .irq(irq_a)
  );
  switch_pio_edge_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DC)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .bus(bus_b), .in_port(in_b), .irq(irq_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit b, input logic [1:0] a, input bit wr, input logic [31:0] d);
    if (b) begin
      bus_b.address = a; bus_b.chipselect = 1'b1; bus_b.write_n = ~wr; bus_b.writedata = d;
    end else begin
      bus_a.address = a; bus_a.chipselect = 1'b1; bus_a.write_n = ~wr; bus_a.writedata = d;
    end
  endtask

  task automatic end_write(input bit b);
    if (b) bus_b.write_n = 1'b1;
    else   bus_a.write_n = 1'b1;
  endtask

  task automatic bus_write(input bit b, input logic [1:0] a, input logic [31:0] d);
    drive(b, a, 1'b1, d);
    @(negedge clk);
    end_write(b);
  endtask

  task automatic bus_read(input bit b, input logic [1:0] a, output logic [31:0] r);
    drive(b, a, 1'b0, 32'h0);
    @(negedge clk);
    r = b ? bus_b.readdata : bus_a.readdata;
  endtask

  // Releases reset at the current negedge and tracks STATUS.armed cycle by cycle.
  task automatic arm_check(input bit b, input string nm);
    drive(b, 2'd1, 1'b0, 32'h0);
    if (b) rst_b_n = 1'b1;
    else   rst_a_n = 1'b1;
    for (int k = 1; k <= int'(S) + 2; k++) begin
      @(negedge clk);
      check(nm, b ? bus_b.readdata : bus_a.readdata, STAT0 | ((k >= int'(S) + 2) ? 32'h1 : 32'h0));
    end
  endtask

  typedef struct {
    logic [W-1:0] in_val;
    logic [1:0]   addr;
    bit           wr;
    logic [31:0]  wdata;
    bit           settle;
    logic [31:0]  exp_rd;
    logic         exp_irq;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{10'h3FF, 2'd0, 1'b0, 32'h0,         1'b0, 32'h3FF,          1'b0};
    tbl[1]  = '{10'h3FF, 2'd3, 1'b0, 32'h0,         1'b0, 32'h0,            1'b0};
    tbl[2]  = '{10'h3FF, 2'd2, 1'b1, 32'h1,         1'b0, 32'h1,            1'b0};
    tbl[3]  = '{10'h3FE, 2'd0, 1'b0, 32'h0,         1'b1, 32'h3FE,          1'b0};
    tbl[4]  = '{10'h3FE, 2'd3, 1'b0, 32'h0,         1'b0, 32'h0,            1'b0};
    tbl[5]  = '{10'h3FF, 2'd3, 1'b0, 32'h0,         1'b1, 32'h1,            1'b1};
    tbl[6]  = '{10'h3FF, 2'd3, 1'b1, 32'h1,         1'b0, 32'h0,            1'b0};
    tbl[7]  = '{10'h3F7, 2'd2, 1'b1, 32'h3FF,       1'b1, 32'h3FF,          1'b0};
    tbl[8]  = '{10'h3FF, 2'd3, 1'b0, 32'h0,         1'b1, 32'h8,            1'b1};
    tbl[9]  = '{10'h3FF, 2'd3, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,            1'b0};
    tbl[10] = '{10'h3FF, 2'd0, 1'b1, 32'h123,       1'b0, 32'h3FF,          1'b0};
    tbl[11] = '{10'h3FF, 2'd1, 1'b1, 32'hFFFF,      1'b0, STAT0 | 32'h1,    1'b0};
    tbl[12] = '{10'h3FF, 2'd2, 1'b1, 32'hFFFF_FC00, 1'b0, 32'h0,            1'b0};
    tbl[13] = '{10'h1FF, 2'd3, 1'b0, 32'h0,         1'b1, 32'h0,            1'b0};
    tbl[14] = '{10'h3FF, 2'd3, 1'b0, 32'h0,         1'b1, 32'h200,          1'b0};
    tbl[15] = '{10'h3FF, 2'd2, 1'b1, 32'h200,       1'b0, 32'h200,          1'b1};
    tbl[16] = '{10'h3FF, 2'd2, 1'b1, 32'h0,         1'b0, 32'h0,            1'b0};
    tbl[17] = '{10'h3FF, 2'd3, 1'b0, 32'h0,         1'b0, 32'h200,          1'b0};
    tbl[18] = '{10'h3FF, 2'd3, 1'b1, 32'h200,       1'b0, 32'h0,            1'b0};

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    in_a = 10'h3FF; in_b = 10'h020;
    bus_a.address = 2'd0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = 2'd0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
    repeat (3) @(negedge clk);
    check("reset_rd_a", bus_a.readdata, 32'h0);
    check("reset_irq_a", {31'b0, irq_a}, 32'h0);
    check("reset_rd_b", bus_b.readdata, 32'h0);

    arm_check(1'b0, "arm_a");
    arm_check(1'b1, "arm_b");

    // Register table on instance A
    for (int i = 0; i < 19; i++) begin
      in_a = tbl[i].in_val;
      drive(1'b0, tbl[i].addr, tbl[i].wr, tbl[i].wdata);
      @(negedge clk);
      end_write(1'b0);
      repeat ((tbl[i].settle ? int'(SETTLE) : 2) - 1) @(negedge clk);
      check($sformatf("vec%0d_rd", i), bus_a.readdata, tbl[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, irq_a}, {31'b0, tbl[i].exp_irq});
    end

    // Capture latency of a rising edge on bit0, then W1C
    bus_write(1'b0, 2'd2, 32'h1);
    in_a = 10'h3FE;
    repeat (SETTLE) @(negedge clk);
    check("lat_pre_irq", {31'b0, irq_a}, 32'h0);
    in_a = 10'h3FF;
    for (int k = 1; k <= int'(CAP_K) + 1; k++) begin
      @(negedge clk);
      check($sformatf("lat_irq_k%0d", k), {31'b0, irq_a}, (k >= int'(CAP_K)) ? 32'h1 : 32'h0);
    end
    bus_write(1'b0, 2'd3, 32'h1);
    check("w1c_irq", {31'b0, irq_a}, 32'h0);

    // W1C on bit3 in the same cycle its rising edge is captured
    bus_write(1'b0, 2'd2, 32'h8);
    in_a = 10'h3F7;
    repeat (SETTLE) @(negedge clk);
    in_a = 10'h3FF;
    repeat (CAP_K - 1) @(negedge clk);
    check("coll_pre_irq", {31'b0, irq_a}, 32'h0);
    drive(1'b0, 2'd3, 1'b1, 32'h8);
    @(negedge clk);
    end_write(1'b0);
    check("coll_irq", {31'b0, irq_a}, 32'h1);
    bus_read(1'b0, 2'd3, rd);
    check("coll_cap", rd, 32'h8);
    bus_write(1'b0, 2'd3, 32'h8);
    check("coll_clr_irq", {31'b0, irq_a}, 32'h0);

`ifdef SWITCH_PIO_DEBOUNCE_EN
    // Short pulse on bit2 is rejected; a long hold is accepted after S+DC cycles
    bus_write(1'b0, 2'd2, 32'h4);
    in_a = 10'h3FB;
    repeat (SETTLE) @(negedge clk);
    in_a = 10'h3FF;
    repeat (10) @(negedge clk);
    in_a = 10'h3FB;
    repeat (SETTLE) @(negedge clk);
    bus_read(1'b0, 2'd0, rd);
    check("db_pulse_data", rd, 32'h3FB);
    bus_read(1'b0, 2'd3, rd);
    check("db_pulse_cap", rd, 32'h0);
    check("db_pulse_irq", {31'b0, irq_a}, 32'h0);
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    in_a = 10'h3FF;
    for (int k = 1; k <= int'(CAP_K); k++) begin
      @(negedge clk);
      check($sformatf("db_hold_k%0d", k), {31'b0, bus_a.readdata[2]}, (k >= int'(CAP_K)) ? 32'h1 : 32'h0);
    end
    bus_read(1'b0, 2'd3, rd);
    check("db_hold_cap", rd, 32'h4);
    check("db_hold_irq", {31'b0, irq_a}, 32'h1);
    bus_write(1'b0, 2'd3, 32'h4);
`endif

    // Any-edge instance B: bit5 1->0->1 with mask 0, then unmask
    bus_read(1'b1, 2'd3, rd);
    check("b_held_cap", rd, 32'h0);
    in_b = 10'h000;
    repeat (SETTLE) @(negedge clk);
    bus_read(1'b1, 2'd3, rd);
    check("b_fall_cap", rd, 32'h20);
    check("b_fall_irq", {31'b0, irq_b}, 32'h0);
    bus_write(1'b1, 2'd3, 32'h20);
    in_b = 10'h020;
    repeat (SETTLE) @(negedge clk);
    bus_read(1'b1, 2'd3, rd);
    check("b_rise_cap", rd, 32'h20);
    check("b_rise_irq", {31'b0, irq_b}, 32'h0);
    bus_write(1'b1, 2'd2, 32'h20);
    check("b_unmask_irq", {31'b0, irq_b}, 32'h1);
    bus_write(1'b1, 2'd2, 32'h3FF);
    in_b = 10'h003;
    repeat (SETTLE) @(negedge clk);
    bus_read(1'b1, 2'd3, rd);
    check("b_multi_cap", rd, 32'h23);
    check("b_multi_irq", {31'b0, irq_b}, 32'h1);

    // Asynchronous reset mid-run with captures pending
    #2 rst_b_n = 1'b0;
    #1;
    check("b_async_irq", {31'b0, irq_b}, 32'h0);
    check("b_async_rd", bus_b.readdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    arm_check(1'b1, "b_rearm");
    bus_read(1'b1, 2'd2, rd);
    check("b_mask_after_rst", rd, 32'h0);
    bus_read(1'b1, 2'd3, rd);
    check("b_cap_after_rst", rd, 32'h0);
    check("b_irq_after_rst", {31'b0, irq_b}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
